sap_control_sequencer: RTL and testbench
========================================

# sap_control_sequencer

Microcoded T-state sequencer for the 8-bit accumulator computer. It replaces the free-running ring counter with a state machine that supports variable-length instructions, free-run and single-step modes, and a sticky halt. It reads the opcode from the instruction register and drives one active-high control line per datapath load or enable: PC, MAR, RAM, IR, ACC, B/temp, ALU, output register. It also counts retired instructions.

## Interface
- CNT_W, default 8: width of the retired-instruction counter.
- clk  input  1  system clock; all state changes on rising edge.
- clr  input  1  reset, asynchronous, active-low.
- run  input  1  level; 1 = execute instructions back-to-back.
- step  input  1  single-step request; a 0->1 transition starts exactly one instruction.
- opcode  input  4  IR[7:4]; valid from T4 onward.
- pc_out, pc_inc  output  1 each  PC drives bus / PC increments.
- mar_ld  output  1  MAR loads bus[3:0].
- ram_out  output  1  ROM/RAM drives bus.
- ir_ld, ir_out  output  1 each  IR loads bus / IR operand field drives bus[3:0].
- acc_ld, acc_out  output  1 each  accumulator load / drive.
- b_ld  output  1  B (temp) register loads bus.
- alu_out, alu_sub  output  1 each  ALU drives bus / ALU subtracts (0 = add).
- out_ld  output  1  output register loads bus.
- tstate  output  3  current state code.
- busy  output  1  high in T1..T6.
- halted  output  1  high in HALT.
- instr_done  output  1  high during the final T-state of every instruction.
- retired  output  CNT_W  count of completed instructions; wraps.

## Operation
- State codes: IDLE=0, T1..T6=1..6, HALT=7.
- Opcodes: 0000 LDA, 0001 ADD, 0010 SUB, 1110 OUT, 1111 HLT; all others are NOP.
- Fetch, common to all instructions:
  - T1: pc_out, mar_ld.
  - T2: pc_inc.
  - T3: ram_out, ir_ld.
- LDA: T4 ir_out, mar_ld; T5 ram_out, acc_ld (final state).
- ADD: T4 ir_out, mar_ld; T5 ram_out, b_ld; T6 alu_out, acc_ld (final state).
- SUB: same as ADD, with alu_sub also asserted in T6.
- OUT: T4 acc_out, out_ld (final state).
- HLT and NOP: T4 with no controls asserted (final state).
- Controls are a combinational decode of the registered state and opcode.
  - All controls are 0 in IDLE and HALT.
  - At most one *_out is high in any state, so the bus never has two drivers.
- Transitions:
  - IDLE -> T1 when run=1 or a step edge is detected.
  - Tn -> Tn+1 when Tn is not the final state of the current instruction.
  - Final state -> HALT if the opcode is HLT.
  - Otherwise, final state -> T1 if run=1, else -> IDLE.
  - HALT is left only by reset.
- Step edge:
  - step is registered internally.
  - An edge is step=1 with the previous sample 0; it is only honoured in IDLE.
  - Edges arriving while busy are discarded, not queued.
- Dropping run mid-instruction lets the current instruction finish, then the sequencer enters IDLE.
- retired increments by 1 on the clock edge that ends each final state, including HLT, and wraps from all-ones to 0.

## Timing
- Reset (clr=0, asynchronous):
  - tstate=IDLE, retired=0, step history=0.
  - All controls, busy, halted and instr_done read 0.
- Latency from start request: run sampled high in IDLE gives T1 on the next cycle.
- Instruction lengths: LDA 5 cycles; ADD/SUB 6; OUT/HLT/NOP 4.
- Continuous run has no IDLE bubble between instructions.
- Opcode is ignored in IDLE and T1..T3. It must be stable from T4 through the final state.
- Reset mid-instruction aborts immediately with no partial count. The first instruction after clr release re-fetches from T1.
- run and step asserted in the same IDLE cycle produce one start, then the run rules apply.
- In HALT, run and step have no effect; halted stays 1.

## Test plan
- Reset with clr=0 during T5 of LDA -> tstate=0, all controls 0, retired=0 within the same cycle; the instruction is not counted.
- run=1 with opcodes LDA, ADD, SUB, OUT -> tstate sequence 1-5, 1-6, 1-6, 1-4 back-to-back; alu_sub high only in the SUB T6; retired=4.
- run=0, step held high for 20 cycles with opcode ADD -> exactly one instruction (T1..T6), then IDLE; retired=1.
- Second step edge during T3 of an LDA step -> ignored; returns to IDLE after T5; retired=1.
- run=1 with opcode HLT -> T1..T4, then tstate=7 and halted=1 indefinitely while run and step toggle; retired=1; clr pulse -> IDLE.
- Opcode 0101 -> NOP lasting T1..T4 with no controls in T4; instr_done high in T4; retired increments; every cycle has at most one *_out high.

Source files
------------

// File: rtl/sap_control_sequencer.sv
// T-state sequencer for the 8-bit accumulator machine. It supports variable-length
// instructions, free-run and single-step modes, and a sticky halt.
module sap_control_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       opcode,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             mar_ld,
    output logic             ram_out,
    output logic             ir_ld,
    output logic             ir_out,
    output logic             acc_ld,
    output logic             acc_out,
    output logic             b_ld,
    output logic             alu_out,
    output logic             alu_sub,
    output logic             out_ld,
    output logic [2:0]       tstate,
    output logic             busy,
    output logic             halted,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T1   = 3'd1,
        S_T2   = 3'd2,
        S_T3   = 3'd3,
        S_T4   = 3'd4,
        S_T5   = 3'd5,
        S_T6   = 3'd6,
        S_HALT = 3'd7
    } state_t;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    state_t           r_state;
    logic             r_step_prev;
    logic [CNT_W-1:0] r_retired;

    logic w_busy;
    logic w_final;
    logic w_step_edge;
    logic w_is_alu;

    assign w_busy      = (r_state != S_IDLE) && (r_state != S_HALT);
    assign w_step_edge = step && !r_step_prev;
    assign w_is_alu    = (opcode == OP_ADD) || (opcode == OP_SUB);

    // Final T-state depends on the opcode: LDA ends in T5, ADD/SUB in T6, all else in T4.
    always_comb begin
        w_final = 1'b0;
        case (r_state)
            S_T4:    w_final = (opcode != OP_LDA) && !w_is_alu;
            S_T5:    w_final = (opcode == OP_LDA);
            S_T6:    w_final = w_is_alu;
            default: w_final = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_step_prev <= 1'b0;
            r_retired   <= '0;
        end else begin
            r_step_prev <= step;
            case (r_state)
                S_IDLE: begin
                    if (run || w_step_edge) r_state <= S_T1;
                end
                S_HALT: r_state <= S_HALT;
                default: begin
                    if (w_final) begin
                        r_retired <= r_retired + CNT_W'(1);
                        if (opcode == OP_HLT) r_state <= S_HALT;
                        else if (run)         r_state <= S_T1;
                        else                  r_state <= S_IDLE;
                    end else begin
                        r_state <= state_t'(r_state + 3'd1);
                    end
                end
            endcase
        end
    end

    // Decode keeps at most one bus driver (*_out) active in any state.
    always_comb begin
        pc_out  = 1'b0;
        pc_inc  = 1'b0;
        mar_ld  = 1'b0;
        ram_out = 1'b0;
        ir_ld   = 1'b0;
        ir_out  = 1'b0;
        acc_ld  = 1'b0;
        acc_out = 1'b0;
        b_ld    = 1'b0;
        alu_out = 1'b0;
        alu_sub = 1'b0;
        out_ld  = 1'b0;
        case (r_state)
            S_T1: begin
                pc_out = 1'b1;
                mar_ld = 1'b1;
            end
            S_T2: pc_inc = 1'b1;
            S_T3: begin
                ram_out = 1'b1;
                ir_ld   = 1'b1;
            end
            S_T4: begin
                if ((opcode == OP_LDA) || w_is_alu) begin
                    ir_out = 1'b1;
                    mar_ld = 1'b1;
                end else if (opcode == OP_OUT) begin
                    acc_out = 1'b1;
                    out_ld  = 1'b1;
                end
            end
            S_T5: begin
                if (opcode == OP_LDA) begin
                    ram_out = 1'b1;
                    acc_ld  = 1'b1;
                end else if (w_is_alu) begin
                    ram_out = 1'b1;
                    b_ld    = 1'b1;
                end
            end
            S_T6: begin
                if (w_is_alu) begin
                    alu_out = 1'b1;
                    acc_ld  = 1'b1;
                    alu_sub = (opcode == OP_SUB);
                end
            end
            default: ;
        endcase
    end

    assign tstate     = r_state;
    assign busy       = w_busy;
    assign halted     = (r_state == S_HALT);
    assign instr_done = w_busy && w_final;
    assign retired    = r_retired;

endmodule

// File: tb/tb_sap_control_sequencer.sv
// Directed bench for sap_control_sequencer: a queue holds the expected T-state and
// control word for each busy cycle, filled from the instruction tables as stimulus is issued.
module tb_sap_control_sequencer;

    localparam int CNT_W = 8;

    localparam logic [11:0] C_PC_OUT  = 12'h800;
    localparam logic [11:0] C_PC_INC  = 12'h400;
    localparam logic [11:0] C_MAR_LD  = 12'h200;
    localparam logic [11:0] C_RAM_OUT = 12'h100;
    localparam logic [11:0] C_IR_LD   = 12'h080;
    localparam logic [11:0] C_IR_OUT  = 12'h040;
    localparam logic [11:0] C_ACC_LD  = 12'h020;
    localparam logic [11:0] C_ACC_OUT = 12'h010;
    localparam logic [11:0] C_B_LD    = 12'h008;
    localparam logic [11:0] C_ALU_OUT = 12'h004;
    localparam logic [11:0] C_ALU_SUB = 12'h002;
    localparam logic [11:0] C_OUT_LD  = 12'h001;

    typedef struct packed {
        logic [2:0]  ts;
        logic [11:0] ctrl;
        logic        done;
    } exp_t;

    logic             clk;
    logic             clr;
    logic             run;
    logic             step;
    logic [3:0]       opcode;
    logic             pc_out, pc_inc, mar_ld, ram_out, ir_ld, ir_out;
    logic             acc_ld, acc_out, b_ld, alu_out, alu_sub, out_ld;
    logic [2:0]       tstate;
    logic             busy, halted, instr_done;
    logic [CNT_W-1:0] retired;

    logic [11:0] ctrl_vec;
    exp_t        exp_q[$];
    int          n_cmp;
    int          n_err;

    assign ctrl_vec = {pc_out, pc_inc, mar_ld, ram_out, ir_ld, ir_out,
                       acc_ld, acc_out, b_ld, alu_out, alu_sub, out_ld};

    sap_control_sequencer #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .clr        (clr),
        .run        (run),
        .step       (step),
        .opcode     (opcode),
        .pc_out     (pc_out),
        .pc_inc     (pc_inc),
        .mar_ld     (mar_ld),
        .ram_out    (ram_out),
        .ir_ld      (ir_ld),
        .ir_out     (ir_out),
        .acc_ld     (acc_ld),
        .acc_out    (acc_out),
        .b_ld       (b_ld),
        .alu_out    (alu_out),
        .alu_sub    (alu_sub),
        .out_ld     (out_ld),
        .tstate     (tstate),
        .busy       (busy),
        .halted     (halted),
        .instr_done (instr_done),
        .retired    (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_instr(input logic [3:0] op);
        exp_q.push_back('{3'd1, C_PC_OUT | C_MAR_LD, 1'b0});
        exp_q.push_back('{3'd2, C_PC_INC, 1'b0});
        exp_q.push_back('{3'd3, C_RAM_OUT | C_IR_LD, 1'b0});
        case (op)
            4'b0000: begin
                exp_q.push_back('{3'd4, C_IR_OUT | C_MAR_LD, 1'b0});
                exp_q.push_back('{3'd5, C_RAM_OUT | C_ACC_LD, 1'b1});
            end
            4'b0001, 4'b0010: begin
                exp_q.push_back('{3'd4, C_IR_OUT | C_MAR_LD, 1'b0});
                exp_q.push_back('{3'd5, C_RAM_OUT | C_B_LD, 1'b0});
                exp_q.push_back('{3'd6, C_ALU_OUT | C_ACC_LD | ((op == 4'b0010) ? C_ALU_SUB : 12'h000), 1'b1});
            end
            4'b1110: exp_q.push_back('{3'd4, C_ACC_OUT | C_OUT_LD, 1'b1});
            default: exp_q.push_back('{3'd4, 12'h000, 1'b1});
        endcase
    endtask

    // Advance n cycles, checking each busy cycle against the queue head.
    task automatic run_cycles(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("one_driver", 32'($countones({pc_out, ram_out, ir_out, acc_out, alu_out}) <= 1), 32'd1);
            if (busy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_busy_tstate", 32'(tstate), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("tstate", 32'(tstate), 32'(e.ts));
                    chk("ctrl", 32'(ctrl_vec), 32'(e.ctrl));
                    chk("instr_done", 32'(instr_done), 32'(e.done));
                    $display("cycle t=%0t tstate=%0d ctrl=%03h done=%0b retired=%0d",
                             $time, tstate, ctrl_vec, instr_done, retired);
                end
            end else begin
                chk("idle_ctrl", 32'(ctrl_vec), 32'd0);
                chk("idle_done", 32'(instr_done), 32'd0);
            end
        end
    endtask

    task automatic drain_check(input string tag);
        chk(tag, 32'(exp_q.size()), 32'd0);
        exp_q.delete();
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        clr    = 1'b0;
        run    = 1'b0;
        step   = 1'b0;
        opcode = 4'b0000;

        // Reset state
        #1;
        chk("rst_tstate", 32'(tstate), 32'd0);
        chk("rst_retired", 32'(retired), 32'd0);
        chk("rst_ctrl", 32'(ctrl_vec), 32'd0);
        chk("rst_flags", 32'({busy, halted, instr_done}), 32'd0);
        @(negedge clk);
        clr = 1'b1;

        // Asynchronous reset during T5 of an LDA
        run    = 1'b1;
        opcode = 4'b0000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tstate == 3'd5) break;
        end
        chk("reach_t5", 32'(tstate), 32'd5);
        clr = 1'b0;
        #1;
        chk("abort_tstate", 32'(tstate), 32'd0);
        chk("abort_ctrl", 32'(ctrl_vec), 32'd0);
        chk("abort_retired", 32'(retired), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        run = 1'b0;
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        chk("post_abort_retired", 32'(retired), 32'd0);

        // Back-to-back LDA, ADD, SUB, then OUT with run dropped mid-instruction
        run    = 1'b1;
        opcode = 4'b0000;
        push_instr(4'b0000); run_cycles(1); opcode = 4'b0000; run_cycles(4);
        push_instr(4'b0001); run_cycles(1); opcode = 4'b0001; run_cycles(5);
        push_instr(4'b0010); run_cycles(1); opcode = 4'b0010; run_cycles(5);
        push_instr(4'b1110); run_cycles(1); opcode = 4'b1110; run = 1'b0; run_cycles(3);
        run_cycles(1);
        chk("b2b_idle", 32'(tstate), 32'd0);
        chk("b2b_retired", 32'(retired), 32'd4);
        drain_check("b2b_drain");

        // Step held high for 20 cycles: exactly one ADD
        opcode = 4'b0001;
        step   = 1'b1;
        push_instr(4'b0001);
        run_cycles(20);
        chk("step_hold_idle", 32'(tstate), 32'd0);
        chk("step_hold_retired", 32'(retired), 32'd5);
        drain_check("step_hold_drain");
        step = 1'b0;
        run_cycles(1);

        // Second step edge during an LDA is discarded
        opcode = 4'b0000;
        step   = 1'b1;
        push_instr(4'b0000);
        run_cycles(1);
        step = 1'b0;
        run_cycles(2);
        step = 1'b1;
        run_cycles(2);
        run_cycles(4);
        chk("step_ignore_idle", 32'(tstate), 32'd0);
        chk("step_ignore_retired", 32'(retired), 32'd6);
        drain_check("step_ignore_drain");
        step = 1'b0;
        run_cycles(1);

        // Unassigned opcode 0101 behaves as a four-cycle NOP
        opcode = 4'b0101;
        step   = 1'b1;
        push_instr(4'b0101);
        run_cycles(6);
        chk("nop_retired", 32'(retired), 32'd7);
        drain_check("nop_drain");
        step = 1'b0;
        run_cycles(1);

        // HLT is sticky; run/step toggling has no effect; clr leaves HALT
        opcode = 4'b1111;
        run    = 1'b1;
        push_instr(4'b1111);
        run_cycles(4);
        for (int i = 0; i < 8; i++) begin
            run  = i[0];
            step = i[1];
            run_cycles(1);
            chk("halt_tstate", 32'(tstate), 32'd7);
            chk("halt_flag", 32'(halted), 32'd1);
        end
        chk("halt_retired", 32'(retired), 32'd8);
        drain_check("halt_drain");
        clr = 1'b0;
        #1;
        chk("halt_clr_tstate", 32'(tstate), 32'd0);
        chk("halt_clr_halted", 32'(halted), 32'd0);
        chk("halt_clr_retired", 32'(retired), 32'd0);
        run  = 1'b0;
        step = 1'b0;
        @(negedge clk);
        clr = 1'b1;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
